cnn_layer_result_buffer: RTL and testbench

Parametrised per-layer coefficient store and result buffer for the CNN pipeline. Holds the 3x3 weights and the bias for CH parallel convolution channels and drives them to the channel datapaths. Captures one frame of CH-wide results at a run-time frame length and serves random-access reads to the next layer. Generalises the fixed 4-channel, 256-pixel layer-1 top with run-time frame length, restart, coefficient lock and error flags.

---
 rtl/cnn_layer_result_buffer.sv | 166 ++++++++++++++++
 tb/tb_cnn_layer_result_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_result_buffer.sv
// Per-layer coefficient store (3x3 weights + bias per channel) and single-frame
// result buffer with run-time frame length, restart and sticky error flags.
module cnn_layer_result_buffer #(
    parameter int DW    = 24,
    parameter int CH    = 4,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int WAW   = $clog2(9 * CH),
    parameter int BAW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [AW:0]         FRAME_LEN,
    input  logic                W_WEN,
    input  logic                W_REN,
    input  logic [WAW-1:0]      W_ADDR,
    input  logic [DW-1:0]       W_WDATA,
    output logic [DW-1:0]       W_RDATA,
    input  logic                B_WEN,
    input  logic                B_REN,
    input  logic [BAW-1:0]      B_ADDR,
    input  logic [DW-1:0]       B_WDATA,
    output logic [DW-1:0]       B_RDATA,
    output logic [9*CH*DW-1:0]  W_FLAT,
    output logic [CH*DW-1:0]    B_FLAT,
    input  logic                DIN_VALID,
    input  logic                DIN_LAST,
    input  logic [CH*DW-1:0]    DIN,
    output logic                BUSY,
    output logic                FINISHED,
    output logic [AW:0]         FRAME_COUNT,
    output logic                ERR_SHORT,
    output logic                ERR_OVERFLOW,
    input  logic                READ_EN,
    input  logic [AW-1:0]       READ_ADDR,
    output logic                READ_VALID,
    output logic [CH*DW-1:0]    DATA_OUT
);

    localparam int NW = 9 * CH;
    localparam logic [WAW:0] NW_L    = (WAW + 1)'(NW);
    localparam logic [BAW:0] NB_L    = (BAW + 1)'(CH);
    localparam logic [AW:0]  DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t             state;
    logic [DW-1:0]      w_mem [NW];
    logic [DW-1:0]      b_mem [CH];
    logic [CH*DW-1:0]   r_mem [DEPTH];

    logic [AW:0]        frame_count;
    logic [AW:0]        len_p0;
    logic [AW:0]        next_count;
    logic [AW:0]        start_len;
    logic               err_short;
    logic               err_overflow;
    logic               w_in_range;
    logic               b_in_range;
    logic               coef_wr_ok;
    logic               cap_wr;
    logic               rd_hit;

    logic [DW-1:0]      w_rdata_p1;
    logic [DW-1:0]      b_rdata_p1;
    logic               rd_vld_p1;
    logic [CH*DW-1:0]   rd_data_p1;

    assign w_in_range = {1'b0, W_ADDR} < NW_L;
    assign b_in_range = {1'b0, B_ADDR} < NB_L;
    assign coef_wr_ok = (state != CAPTURE);
    assign next_count = frame_count + 1'b1;
    // A zero or oversized length means "fill the whole buffer".
    assign start_len  = (FRAME_LEN == '0 || FRAME_LEN > DEPTH_L) ? DEPTH_L : FRAME_LEN;
    assign cap_wr     = !RST && !START && (state == CAPTURE) && DIN_VALID;
    assign rd_hit     = (state == DONE) && READ_EN && !START &&
                        ({1'b0, READ_ADDR} < frame_count);

    // Coefficient storage: not reset, frozen while a frame is being captured.
    always_ff @(posedge CLK) begin
        if (W_WEN && coef_wr_ok && w_in_range)
            w_mem[W_ADDR] <= W_WDATA;
        if (B_WEN && coef_wr_ok && b_in_range)
            b_mem[B_ADDR] <= B_WDATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_rdata_p1 <= '0;
            b_rdata_p1 <= '0;
        end else begin
            if (W_REN)
                w_rdata_p1 <= w_in_range ? w_mem[W_ADDR] : '0;
            if (B_REN)
                b_rdata_p1 <= b_in_range ? b_mem[B_ADDR] : '0;
        end
    end

    for (genvar i = 0; i < NW; i++) begin : g_wflat
        assign W_FLAT[i*DW +: DW] = w_mem[i];
    end
    for (genvar c = 0; c < CH; c++) begin : g_bflat
        assign B_FLAT[c*DW +: DW] = b_mem[c];
    end

    // Result storage: written at the current count, never reset.
    always_ff @(posedge CLK) begin
        if (cap_wr)
            r_mem[frame_count[AW-1:0]] <= DIN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            frame_count  <= '0;
            len_p0       <= '0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else if (START) begin
            state        <= CAPTURE;
            frame_count  <= '0;
            len_p0       <= start_len;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (DIN_VALID) begin
                        frame_count <= next_count;
                        if (next_count == len_p0 || DIN_LAST)
                            state <= DONE;
                        if (DIN_LAST && next_count < len_p0)
                            err_short <= 1'b1;
                    end
                end
                default: begin
                    if (DIN_VALID)
                        err_overflow <= 1'b1;
                end
            endcase
        end
    end

    // Read stage p1: one-cycle registered response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            rd_vld_p1  <= rd_hit;
            rd_data_p1 <= rd_hit ? r_mem[READ_ADDR] : '0;
        end
    end

    assign W_RDATA      = w_rdata_p1;
    assign B_RDATA      = b_rdata_p1;
    assign BUSY         = (state == CAPTURE);
    assign FINISHED     = (state == DONE);
    assign FRAME_COUNT  = frame_count;
    assign ERR_SHORT    = err_short;
    assign ERR_OVERFLOW = err_overflow;
    assign READ_VALID   = rd_vld_p1;
    assign DATA_OUT     = rd_data_p1;

endmodule

// File: tb/tb_cnn_layer_result_buffer.sv
// Directed bench for cnn_layer_result_buffer; read responses are checked by a
// scoreboard monitor, status/coefficient outputs by direct compares.
module tb_cnn_layer_result_buffer;

    localparam int DW    = 24;
    localparam int CH    = 4;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int WAW   = $clog2(9 * CH);
    localparam int BAW   = $clog2(CH);

    logic                CLK = 1'b0;
    logic                RST;
    logic                START;
    logic [AW:0]         FRAME_LEN;
    logic                W_WEN, W_REN;
    logic [WAW-1:0]      W_ADDR;
    logic [DW-1:0]       W_WDATA;
    logic [DW-1:0]       W_RDATA;
    logic                B_WEN, B_REN;
    logic [BAW-1:0]      B_ADDR;
    logic [DW-1:0]       B_WDATA;
    logic [DW-1:0]       B_RDATA;
    logic [9*CH*DW-1:0]  W_FLAT;
    logic [CH*DW-1:0]    B_FLAT;
    logic                DIN_VALID, DIN_LAST;
    logic [CH*DW-1:0]    DIN;
    logic                BUSY, FINISHED;
    logic [AW:0]         FRAME_COUNT;
    logic                ERR_SHORT, ERR_OVERFLOW;
    logic                READ_EN;
    logic [AW-1:0]       READ_ADDR;
    logic                READ_VALID;
    logic [CH*DW-1:0]    DATA_OUT;

    int total = 0;
    int bad   = 0;

    logic             exp_v[$];
    logic [CH*DW-1:0] exp_d[$];

    cnn_layer_result_buffer #(.DW(DW), .CH(CH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .START(START), .FRAME_LEN(FRAME_LEN),
        .W_WEN(W_WEN), .W_REN(W_REN), .W_ADDR(W_ADDR), .W_WDATA(W_WDATA), .W_RDATA(W_RDATA),
        .B_WEN(B_WEN), .B_REN(B_REN), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_RDATA(B_RDATA),
        .W_FLAT(W_FLAT), .B_FLAT(B_FLAT),
        .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST), .DIN(DIN),
        .BUSY(BUSY), .FINISHED(FINISHED), .FRAME_COUNT(FRAME_COUNT),
        .ERR_SHORT(ERR_SHORT), .ERR_OVERFLOW(ERR_OVERFLOW),
        .READ_EN(READ_EN), .READ_ADDR(READ_ADDR), .READ_VALID(READ_VALID), .DATA_OUT(DATA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Channel c of sample n carries base + 256*c + n.
    function automatic logic [CH*DW-1:0] pat(input int n, input int base);
        logic [CH*DW-1:0] r;
        for (int c = 0; c < CH; c++)
            r[c*DW +: DW] = DW'(base + 256 * c + n);
        return r;
    endfunction

    task automatic rd(input int addr, input logic v, input logic [CH*DW-1:0] d);
        READ_EN   = 1'b1;
        READ_ADDR = AW'(addr);
        exp_v.push_back(v);
        exp_d.push_back(d);
        tick();
        READ_EN   = 1'b0;
    endtask

    task automatic send(input int n, input int base, input logic last);
        DIN_VALID = 1'b1;
        DIN_LAST  = last;
        DIN       = pat(n, base);
        tick();
        DIN_VALID = 1'b0;
        DIN_LAST  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    BUSY, 0);
        check({tag, "_fin"},     FINISHED, 0);
        check({tag, "_count"},   FRAME_COUNT, 0);
        check({tag, "_eshort"},  ERR_SHORT, 0);
        check({tag, "_eovf"},    ERR_OVERFLOW, 0);
        check({tag, "_rvalid"},  READ_VALID, 0);
        check({tag, "_dout"},    DATA_OUT, 0);
        check({tag, "_wrdata"},  W_RDATA, 0);
        check({tag, "_brdata"},  B_RDATA, 0);
    endtask

    // Scoreboard monitor: every cycle with a read request is answered one edge later.
    initial begin
        logic issued;
        forever begin
            @(posedge CLK);
            issued = READ_EN;
            @(negedge CLK);
            if (issued) begin
                if (exp_v.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got response with no expectation queued");
                end else begin
                    logic             ev;
                    logic [CH*DW-1:0] ed;
                    ev = exp_v.pop_front();
                    ed = exp_d.pop_front();
                    check("sb_valid", READ_VALID, ev);
                    check("sb_data", DATA_OUT, ed);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; START = 1'b0; FRAME_LEN = '0;
        W_WEN = 1'b0; W_REN = 1'b0; W_ADDR = '0; W_WDATA = '0;
        B_WEN = 1'b0; B_REN = 1'b0; B_ADDR = '0; B_WDATA = '0;
        DIN_VALID = 1'b0; DIN_LAST = 1'b0; DIN = '0;
        READ_EN = 1'b0; READ_ADDR = '0;
        repeat (3) tick();
        RST = 1'b0;
        check_idle_outputs("reset");

        // Coefficient load and readback
        for (int i = 0; i < 36; i++) begin
            W_WEN = 1'b1; W_ADDR = WAW'(i); W_WDATA = DW'(i + 1);
            tick();
        end
        W_WEN = 1'b0;
        for (int c = 0; c < CH; c++) begin
            B_WEN = 1'b1; B_ADDR = BAW'(c); B_WDATA = DW'(32'h100 + c);
            tick();
        end
        B_WEN = 1'b0;
        W_WEN = 1'b1; W_ADDR = WAW'(40); W_WDATA = 24'h777;
        tick();
        W_WEN = 1'b0;
        check("wflat_35", W_FLAT[35*DW +: DW], 36);
        check("wflat_0",  W_FLAT[0 +: DW], 1);
        check("bflat_3",  B_FLAT[3*DW +: DW], 24'h103);
        W_REN = 1'b1; W_ADDR = WAW'(17);
        tick();
        W_REN = 1'b0;
        check("wread_17", W_RDATA, 18);
        tick();
        check("wread_hold", W_RDATA, 18);
        W_REN = 1'b1; W_ADDR = WAW'(40);
        tick();
        W_REN = 1'b0;
        check("wread_oor", W_RDATA, 0);
        B_REN = 1'b1; B_ADDR = BAW'(2);
        tick();
        B_REN = 1'b0;
        check("bread_2", B_RDATA, 24'h102);

        // Full frame, FRAME_LEN=0 selects the whole buffer
        START = 1'b1; FRAME_LEN = '0;
        tick();
        START = 1'b0;
        check("full_busy", BUSY, 1);
        for (int n = 0; n < 256; n++) begin
            if (n == 0) begin
                W_WEN = 1'b1; W_ADDR = '0; W_WDATA = 24'hABC;
            end
            send(n, 0, 1'b0);
            W_WEN = 1'b0;
            if (n == 254) begin
                check("full_fin_early", FINISHED, 0);
                check("full_busy_early", BUSY, 1);
            end
        end
        check("full_fin", FINISHED, 1);
        check("full_busy_end", BUSY, 0);
        check("full_count", FRAME_COUNT, 256);
        check("wlock", W_FLAT[0 +: DW], 1);
        rd(200, 1'b1, pat(200, 0));
        check("full_rd200_ch2", DATA_OUT[2*DW +: DW], 712);
        rd(0, 1'b1, pat(0, 0));
        rd(255, 1'b1, pat(255, 0));

        // Overflow in DONE leaves memory untouched
        DIN_VALID = 1'b1; DIN = '1;
        tick();
        DIN_VALID = 1'b0;
        check("ovf_flag", ERR_OVERFLOW, 1);
        check("ovf_count", FRAME_COUNT, 256);
        rd(0, 1'b1, pat(0, 0));
        rd(200, 1'b1, pat(200, 0));

        // Short frame terminated by DIN_LAST
        START = 1'b1; FRAME_LEN = 9'd10;
        tick();
        START = 1'b0;
        check("short_ovf_clr", ERR_OVERFLOW, 0);
        check("short_count0", FRAME_COUNT, 0);
        for (int n = 0; n < 6; n++)
            send(n, 24'h5000, n == 5);
        check("short_fin", FINISHED, 1);
        check("short_count", FRAME_COUNT, 6);
        check("short_err", ERR_SHORT, 1);
        rd(7, 1'b0, '0);
        rd(5, 1'b1, pat(5, 24'h5000));
        rd(6, 1'b0, '0);

        // Restart mid-frame; the sample arriving with START is dropped
        START = 1'b1; FRAME_LEN = 9'd300;
        tick();
        START = 1'b0;
        for (int n = 0; n < 3; n++)
            send(n, 24'h6000, 1'b0);
        START = 1'b1; FRAME_LEN = 9'd4; DIN_VALID = 1'b1; DIN = pat(0, 24'h7000);
        tick();
        START = 1'b0; DIN_VALID = 1'b0;
        check("restart_count", FRAME_COUNT, 0);
        check("restart_eshort", ERR_SHORT, 0);
        check("restart_busy", BUSY, 1);
        for (int n = 0; n < 4; n++)
            send(n, 24'h8000, 1'b0);
        check("restart_fin", FINISHED, 1);
        check("restart_count4", FRAME_COUNT, 4);
        check("restart_noshort", ERR_SHORT, 0);
        rd(0, 1'b1, pat(0, 24'h8000));
        rd(3, 1'b1, pat(3, 24'h8000));
        rd(4, 1'b0, '0);

        // Reset in the middle of a capture
        START = 1'b1; FRAME_LEN = '0;
        tick();
        START = 1'b0;
        for (int n = 0; n < 50; n++)
            send(n, 24'h9000, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_idle_outputs("midrst");
        rd(0, 1'b0, '0);
        rd(1, 1'b0, '0);
        rd(2, 1'b0, '0);

        repeat (3) tick();
        check("sb_drain", 128'(exp_v.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
